flappy_game_ctrl: RTL and testbench

Top-level game sequencer for the flappy-bird datapath. Generates the physics frame tick, sequences the bird physics through idle / play / death / game-over, turns the raw flap button into one-tick flap pulses aligned to physics updates, and keeps the current and high score. It sits between the synchronized user inputs and the bird physics, pipe and score-display blocks. The top level uses `phys_tick` as the physics clock-enable.

---
 rtl/game_pkg.sv | 16 +
 rtl/game_tick_gen.sv | 31 +++
 rtl/flappy_game_ctrl.sv | 115 +++++++++++
 tb/tb_flappy_game_ctrl.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: FSM state encoding used by the sequencer and HUD blocks,
// plus default frame divider, death hold and score width.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DYING = 2'd2,
        OVER  = 2'd3
    } game_state_e;

    localparam int TICK_DIV_DEF  = 833333;
    localparam int DEAD_HOLD_DEF = 120;
    localparam int SCORE_W_DEF   = 10;

endpackage

// File: rtl/game_tick_gen.sv
// Physics frame divider: registered one-cycle pulse every TICK_DIV clocks, free-running.
// tick_next is the combinational look-ahead so callers can register tick-aligned outputs.
module game_tick_gen
    import game_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic phys_tick,
    output logic tick_next
);

    localparam int CW = $clog2(TICK_DIV);

    logic [CW-1:0] cnt;

    // phys_tick is registered, so it is raised one count early to land on TICK_DIV-1.
    assign tick_next = (cnt == CW'(TICK_DIV - 2));

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            phys_tick <= 1'b0;
        end else begin
            cnt       <= (cnt == CW'(TICK_DIV - 1)) ? '0 : cnt + CW'(1);
            phys_tick <= tick_next;
        end
    end

endmodule

// File: rtl/flappy_game_ctrl.sv
// Game sequencer: frame tick, IDLE/PLAY/DYING/OVER FSM, tick-aligned flap pulses, score.
// All outputs registered; high score tracking only when FLAPPY_HISCORE_EN is defined.
module flappy_game_ctrl
    import game_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEF,
    parameter int DEAD_HOLD = DEAD_HOLD_DEF,
    parameter int SCORE_W   = SCORE_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               key_flap,
    input  logic               collision,
    input  logic               pipe_passed,
    output logic               phys_tick,
    output logic               phys_enable,
    output logic               phys_restart,
    output logic               flap_pulse,
    output logic [SCORE_W-1:0] score,
    output logic [SCORE_W-1:0] high_score,
    output logic               game_over
);

    localparam int                 DW        = $clog2(DEAD_HOLD + 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    game_state_e   state, next_state;
    logic          tick_next;
    logic          key_prev;
    logic          flap_edge;
    logic          flap_pend;
    logic          dying_done;
    logic [DW-1:0] dead_cnt;
    logic          enable_d, restart_d, over_d;

    game_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk       (clk),
        .reset     (reset),
        .phys_tick (phys_tick),
        .tick_next (tick_next)
    );

    assign flap_edge  = key_flap & ~key_prev;
    assign dying_done = phys_tick && (dead_cnt == DW'(DEAD_HOLD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            phys_enable  <= 1'b0;
            phys_restart <= 1'b1;
            game_over    <= 1'b0;
        end else begin
            state        <= next_state;
            phys_enable  <= enable_d;
            phys_restart <= restart_d;
            game_over    <= over_d;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (flap_edge)  next_state = PLAY;
            PLAY:    if (collision)  next_state = DYING;
            DYING:   if (dying_done) next_state = OVER;
            OVER:    if (flap_edge)  next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    // Decoded from next_state so the registered outputs move with the state itself.
    always_comb begin
        enable_d  = (next_state == PLAY) || (next_state == DYING);
        restart_d = (next_state == IDLE);
        over_d    = (next_state == OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            key_prev   <= 1'b0;
            flap_pend  <= 1'b0;
            flap_pulse <= 1'b0;
            dead_cnt   <= '0;
            score      <= '0;
        end else begin
            key_prev   <= key_flap;
            flap_pulse <= tick_next && flap_pend && (state == PLAY);
            // Delivery wins over a new edge, so edges right before a tick coalesce.
            if ((state != PLAY) || (tick_next && flap_pend)) begin
                flap_pend <= 1'b0;
            end else if (flap_edge) begin
                flap_pend <= 1'b1;
            end
            dead_cnt <= (state == DYING) ? dead_cnt + DW'(phys_tick) : '0;
            if (next_state == IDLE) begin
                score <= '0;
            end else if ((state == PLAY) && !collision && pipe_passed && (score != SCORE_MAX)) begin
                score <= score + SCORE_W'(1);
            end
        end
    end

`ifdef FLAPPY_HISCORE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            high_score <= '0;
        end else if ((state == DYING) && (next_state == OVER) && (score > high_score)) begin
            high_score <= score;
        end
    end
`else
    assign high_score = '0;
`endif

endmodule

// File: tb/tb_flappy_game_ctrl.sv
// Bench for flappy_game_ctrl: directed scenarios plus random play against a rule-level model.
module tb_flappy_game_ctrl;

    localparam int TD   = 4;
    localparam int DH   = 2;
    localparam int SW   = 4;
    localparam int SMAX = 15;
`ifdef FLAPPY_HISCORE_EN
    localparam bit HS_EN = 1'b1;
`else
    localparam bit HS_EN = 1'b0;
`endif
    localparam int M_IDLE = 0, M_PLAY = 1, M_DYING = 2, M_OVER = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          key_flap = 1'b0;
    logic          collision = 1'b0;
    logic          pipe_passed = 1'b0;
    logic          phys_tick, phys_enable, phys_restart, flap_pulse, game_over;
    logic [SW-1:0] score, high_score;

    int checks = 0;
    int failures = 0;

    // Model: cycle number since reset, game phase, undelivered flap edge, scores.
    int m_k, m_state, m_score, m_hs, m_dt, m_ecyc;
    bit m_key_prev, m_epend, m_pulse;

    flappy_game_ctrl #(.TICK_DIV(TD), .DEAD_HOLD(DH), .SCORE_W(SW)) dut (
        .clk          (clk),
        .reset        (reset),
        .key_flap     (key_flap),
        .collision    (collision),
        .pipe_passed  (pipe_passed),
        .phys_tick    (phys_tick),
        .phys_enable  (phys_enable),
        .phys_restart (phys_restart),
        .flap_pulse   (flap_pulse),
        .score        (score),
        .high_score   (high_score),
        .game_over    (game_over)
    );

    always #5 clk = ~clk;

    function automatic bit cur_tick();
        return (m_k % TD) == TD - 1;
    endfunction

    // {phys_tick, phys_enable, phys_restart, flap_pulse, game_over}
    function automatic logic [4:0] exp_flags();
        return {cur_tick(), (m_state == M_PLAY) || (m_state == M_DYING),
                m_state == M_IDLE, m_pulse, m_state == M_OVER};
    endfunction

    task automatic model_update();
        bit edge_v, tick_now, tick_nxt;
        if (reset) begin
            m_k = 0; m_state = M_IDLE; m_score = 0; m_hs = 0; m_dt = 0;
            m_key_prev = 0; m_epend = 0; m_pulse = 0; m_ecyc = 0;
        end else begin
            edge_v   = key_flap && !m_key_prev;
            tick_now = (m_k % TD) == TD - 1;
            tick_nxt = ((m_k + 1) % TD) == TD - 1;
            m_pulse  = 0;
            if (m_state == M_PLAY) begin
                if (m_epend && tick_nxt && m_ecyc <= m_k - 1) begin
                    m_pulse = 1;
                    m_epend = 0;
                end else if (edge_v && !m_epend) begin
                    m_epend = 1;
                    m_ecyc  = m_k;
                end
            end else begin
                m_epend = 0;
            end
            case (m_state)
                M_IDLE: if (edge_v) m_state = M_PLAY;
                M_PLAY: begin
                    if (collision) begin
                        m_state = M_DYING;
                        m_dt    = 0;
                    end else if (pipe_passed && m_score < SMAX) begin
                        m_score = m_score + 1;
                    end
                end
                M_DYING: begin
                    if (tick_now) begin
                        m_dt = m_dt + 1;
                        if (m_dt == DH) begin
                            m_state = M_OVER;
                            if (HS_EN && m_score > m_hs) m_hs = m_score;
                        end
                    end
                end
                default: begin
                    if (edge_v) begin
                        m_state = M_IDLE;
                        m_score = 0;
                    end
                end
            endcase
            m_key_prev = key_flap;
            m_k = m_k + 1;
        end
    endtask

    // Inputs apply to the cycle ending at the next posedge; outputs sampled 1 unit after.
    task automatic step(input logic kf, input logic col, input logic pp);
        key_flap = kf; collision = col; pipe_passed = pp;
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic align_tick();
        for (int i = 0; i < TD + 1; i++) begin
            if (cur_tick()) break;
            step(0, 0, 0);
        end
    endtask

    task automatic test_reset();
        int nt;
        reset = 1'b1;
        step(0, 0, 0);
        step(0, 0, 0);
        checks++;
        if ({phys_tick, phys_enable, phys_restart, flap_pulse, game_over} !== 5'b00100) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00100", {phys_tick, phys_enable, phys_restart, flap_pulse, game_over});
        end
        checks++;
        if (score !== 0 || high_score !== 0) begin
            failures++;
            $display("FAIL reset_scores got=%0d/%0d exp=0/0", score, high_score);
        end
        reset = 1'b0;
        nt = 0;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0);
            checks++;
            if (phys_tick !== ((m_k % TD) == TD - 1)) begin
                failures++;
                $display("FAIL idle_tick cycle=%0d got=%b exp=%b", m_k, phys_tick, (m_k % TD) == TD - 1);
            end
            checks++;
            if (phys_restart !== 1'b1 || phys_enable !== 1'b0 || score !== 0) begin
                failures++;
                $display("FAIL idle_outputs got=%b%b/%0d exp=10/0", phys_restart, phys_enable, score);
            end
            if (phys_tick === 1'b1) nt++;
        end
        checks++;
        if (nt != 3) begin
            failures++;
            $display("FAIL idle_tick_count got=%0d exp=3", nt);
        end
    endtask

    task automatic test_start();
        step(1, 0, 0);
        checks++;
        if (phys_enable !== 1'b1 || phys_restart !== 1'b0) begin
            failures++;
            $display("FAIL start_play got=en%b rs%b exp=en1 rs0", phys_enable, phys_restart);
        end
        for (int i = 0; i < 2 * TD; i++) begin
            step(0, 0, 0);
            checks++;
            if (flap_pulse !== 1'b0) begin
                failures++;
                $display("FAIL start_no_pulse got=%b exp=0", flap_pulse);
            end
        end
    endtask

    task automatic test_flap();
        int t0, np, pc;
        align_tick();
        t0 = m_k;
        step(0, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        np = 0; pc = -1;
        for (int i = 0; i < 2 * TD; i++) begin
            checks++;
            if (flap_pulse !== m_pulse) begin
                failures++;
                $display("FAIL flap_pulse cycle=%0d got=%b exp=%b", m_k, flap_pulse, m_pulse);
            end
            if (flap_pulse === 1'b1) begin
                np++;
                if (pc < 0) pc = m_k;
            end
            step(0, 0, 0);
        end
        checks++;
        if (np != 1 || pc != t0 + TD) begin
            failures++;
            $display("FAIL flap_coalesce got=%0d pulses at %0d exp=1 at %0d", np, pc, t0 + TD);
        end
        align_tick();
        t0 = m_k;
        step(1, 0, 0);
        pc = -1;
        for (int i = 0; i < 2 * TD; i++) begin
            if (flap_pulse === 1'b1 && pc < 0) pc = m_k;
            step(0, 0, 0);
        end
        checks++;
        if (pc != t0 + TD) begin
            failures++;
            $display("FAIL flap_on_tick got=%0d exp=%0d", pc, t0 + TD);
        end
    endtask

    task automatic wait_over(input string name);
        int n;
        n = 0;
        while (game_over !== 1'b1 && n < 40) begin
            step(0, 0, 0);
            n++;
        end
        checks++;
        if (game_over !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout got=%b exp=1", name, game_over);
        end
    endtask

    task automatic test_hiscore();
        int nt;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1);
            step(0, 0, 0);
        end
        checks++;
        if (score !== 5) begin
            failures++;
            $display("FAIL score_count got=%0d exp=5", score);
        end
        step(0, 1, 1);
        checks++;
        if (score !== 5 || phys_enable !== 1'b1 || game_over !== 1'b0) begin
            failures++;
            $display("FAIL collide_wins got=%0d en%b go%b exp=5 en1 go0", score, phys_enable, game_over);
        end
        nt = 0;
        for (int i = 0; i < 40; i++) begin
            if (game_over === 1'b1) break;
            if (phys_tick === 1'b1) nt++;
            step(0, 0, 0);
        end
        checks++;
        if (game_over !== 1'b1 || nt != DH) begin
            failures++;
            $display("FAIL dying_hold got=go%b ticks=%0d exp=go1 ticks=%0d", game_over, nt, DH);
        end
        checks++;
        if (high_score !== (HS_EN ? 5 : 0)) begin
            failures++;
            $display("FAIL hiscore_first got=%0d exp=%0d", high_score, HS_EN ? 5 : 0);
        end
        step(1, 0, 0);
        checks++;
        if (phys_restart !== 1'b1 || score !== 0 || high_score !== (HS_EN ? 5 : 0)) begin
            failures++;
            $display("FAIL over_to_idle got=rs%b %0d/%0d", phys_restart, score, high_score);
        end
        step(0, 0, 0);
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1);
            step(0, 0, 0);
        end
        step(0, 1, 0);
        wait_over("game2");
        checks++;
        if (score !== 3 || high_score !== (HS_EN ? 5 : 0)) begin
            failures++;
            $display("FAIL hiscore_kept got=%0d/%0d exp=3/%0d", score, high_score, HS_EN ? 5 : 0);
        end
        step(1, 0, 0);
        step(0, 0, 0);
    endtask

    task automatic test_saturation();
        int e;
        step(1, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 17; i++) begin
            step(0, 0, 1);
            e = (i + 1 > SMAX) ? SMAX : i + 1;
            checks++;
            if (score !== e) begin
                failures++;
                $display("FAIL score_sat step=%0d got=%0d exp=%0d", i, score, e);
            end
            step(0, 0, 0);
        end
        step(0, 1, 0);
        wait_over("sat");
        checks++;
        if (high_score !== (HS_EN ? SMAX : 0)) begin
            failures++;
            $display("FAIL hiscore_sat got=%0d exp=%0d", high_score, HS_EN ? SMAX : 0);
        end
        step(1, 0, 0);
        step(0, 0, 0);
    endtask

    task automatic test_reset_midplay();
        step(1, 0, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        reset = 1'b1;
        step(0, 0, 0);
        reset = 1'b0;
        checks++;
        if ({phys_tick, phys_enable, phys_restart, flap_pulse, game_over} !== 5'b00100
            || score !== 0 || high_score !== 0) begin
            failures++;
            $display("FAIL reset_midplay got=%b %0d/%0d exp=00100 0/0",
                     {phys_tick, phys_enable, phys_restart, flap_pulse, game_over}, score, high_score);
        end
    endtask

    task automatic test_random();
        logic kf;
        kf = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 3) == 0) kf = ~kf;
            reset = ($urandom_range(0, 999) == 0);
            step(kf, $urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0);
            checks++;
            if ({phys_tick, phys_enable, phys_restart, flap_pulse, game_over} !== exp_flags()) begin
                failures++;
                $display("FAIL rand_flags cycle=%0d got=%b exp=%b", i,
                         {phys_tick, phys_enable, phys_restart, flap_pulse, game_over}, exp_flags());
            end
            checks++;
            if (score !== m_score || high_score !== m_hs) begin
                failures++;
                $display("FAIL rand_scores cycle=%0d got=%0d/%0d exp=%0d/%0d", i, score, high_score, m_score, m_hs);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        #1;
        test_reset();
        test_start();
        test_flap();
        test_hiscore();
        test_saturation();
        test_reset_midplay();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
